// File: rtl/inference_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : inference_sequencer
// Brief    : Run sequencer between drawing front end, TPU and result display.
//            Holds the VGA block in reset after power-up, debounces the confirm
//            button, snapshots the drawn image, pulses the TPU reset, watches
//            TPU completion with a watchdog and latches the result digit.
// Options  : SEQ_REARM_EN - when defined, a press in RESULT starts a new job;
//            otherwise RESULT is terminal until iRst_n.
// Revision : 1.0 - initial release
// ============================================================================
module inference_sequencer #(
  parameter int VGA_RST_CYCLES  = 1000,
  parameter int TPU_RST_CYCLES  = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1048576
) (
  input  logic          clk,
  input  logic          iRst_n,
  input  logic          confirm,
  input  logic [1023:0] user_image,
  input  logic          tpu_done,
  input  logic [3:0]    tpu_num,
  output logic          vga_rstn,
  output logic          tpu_ena,
  output logic          tpu_rstn,
  output logic [1023:0] tpu_image,
  output logic [3:0]    result,
  output logic          disp_ena,
  output logic          done,
  output logic          busy,
  output logic          timeout_err
);

  // One shared counter serves the VGA reset, TPU reset and watchdog phases,
  // so it is sized for the largest of them.
  localparam int c_MAX_A   = (VGA_RST_CYCLES > TIMEOUT_CYCLES) ? VGA_RST_CYCLES : TIMEOUT_CYCLES;
  localparam int c_MAX_CNT = (c_MAX_A > TPU_RST_CYCLES) ? c_MAX_A : TPU_RST_CYCLES;
  localparam int c_CW      = $clog2(c_MAX_CNT + 1);
  localparam int c_DW      = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [c_CW-1:0] c_VGA_LAST  = c_CW'(VGA_RST_CYCLES);
  localparam logic [c_CW-1:0] c_TRST_LAST = c_CW'(TPU_RST_CYCLES - 1);
  localparam logic [c_CW-1:0] c_TOUT_LAST = c_CW'(TIMEOUT_CYCLES - 1);
  localparam logic [c_DW-1:0] c_DB_LAST   = c_DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] c_S_VRST   = 3'd0;
  localparam logic [2:0] c_S_IDLE   = 3'd1;
  localparam logic [2:0] c_S_TRST   = 3'd2;
  localparam logic [2:0] c_S_TRUN   = 3'd3;
  localparam logic [2:0] c_S_RESULT = 3'd4;
  localparam logic [2:0] c_S_ERR    = 3'd5;

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] w_cnt_nxt;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_db_level;
  logic [c_DW-1:0] r_db_cnt;
  logic            r_press;

  logic w_vga_rstn_nxt;
  logic w_tpu_ena_nxt;
  logic w_tpu_rstn_nxt;
  logic w_disp_ena_nxt;
  logic w_done_nxt;
  logic w_busy_nxt;
  logic w_terr_nxt;
  logic w_snap;
  logic w_res_ld;

  logic w_vga_last;
  logic w_trst_last;
  logic w_tout_last;

  assign w_vga_last  = (r_cnt == c_VGA_LAST);
  assign w_trst_last = (r_cnt == c_TRST_LAST);
  assign w_tout_last = (r_cnt == c_TOUT_LAST);

  // Confirm button: two-flop synchronizer, debouncer and one-cycle press pulse.
  // The pulse is registered on the same edge the debounced level rises.
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
      r_press    <= 1'b0;
    end else begin
      r_sync1 <= confirm;
      r_sync2 <= r_sync1;
      r_press <= (r_sync2 != r_db_level) && (r_db_cnt == c_DB_LAST) && r_sync2;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_DB_LAST) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + c_DW'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= c_S_VRST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; unknown encodings fall back to the VGA reset phase.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_VRST: begin
        if (w_vga_last) w_state_nxt = c_S_IDLE;
      end
      c_S_IDLE: begin
        if (r_press) w_state_nxt = c_S_TRST;
      end
      c_S_TRST: begin
        if (w_trst_last) w_state_nxt = c_S_TRUN;
      end
      c_S_TRUN: begin
        // A completion in the same cycle as the watchdog expiry still counts.
        if (tpu_done)         w_state_nxt = c_S_RESULT;
        else if (w_tout_last) w_state_nxt = c_S_ERR;
      end
      c_S_RESULT: begin
`ifdef SEQ_REARM_EN
        if (r_press) w_state_nxt = c_S_TRST;
`endif
      end
      c_S_ERR: begin
        w_state_nxt = c_S_ERR;
      end
      default: begin
        w_state_nxt = c_S_VRST;
      end
    endcase
  end

  // Next values of the registered outputs and the shared phase counter.
  always_comb begin
    w_vga_rstn_nxt = vga_rstn;
    w_tpu_ena_nxt  = tpu_ena;
    w_tpu_rstn_nxt = tpu_rstn;
    w_disp_ena_nxt = disp_ena;
    w_done_nxt     = done;
    w_busy_nxt     = busy;
    w_terr_nxt     = timeout_err;
    w_snap         = 1'b0;
    w_res_ld       = 1'b0;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      c_S_VRST: begin
        if (w_vga_last) begin
          w_vga_rstn_nxt = 1'b1;
          w_cnt_nxt      = '0;
        end else begin
          w_vga_rstn_nxt = 1'b0;
          w_cnt_nxt      = r_cnt + c_CW'(1);
        end
      end
      c_S_IDLE: begin
        if (r_press) begin
          w_snap         = 1'b1;
          w_tpu_ena_nxt  = 1'b1;
          w_tpu_rstn_nxt = 1'b0;
          w_busy_nxt     = 1'b1;
          w_cnt_nxt      = '0;
        end
      end
      c_S_TRST: begin
        w_busy_nxt = 1'b1;
        if (w_trst_last) begin
          w_tpu_rstn_nxt = 1'b1;
          w_cnt_nxt      = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CW'(1);
        end
      end
      c_S_TRUN: begin
        if (tpu_done) begin
          w_res_ld       = 1'b1;
          w_disp_ena_nxt = 1'b1;
          w_done_nxt     = 1'b1;
          w_busy_nxt     = 1'b0;
          w_cnt_nxt      = '0;
        end else if (w_tout_last) begin
          w_terr_nxt    = 1'b1;
          w_tpu_ena_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
          w_cnt_nxt     = '0;
        end else begin
          w_busy_nxt = 1'b1;
          w_cnt_nxt  = r_cnt + c_CW'(1);
        end
      end
      c_S_RESULT: begin
        // The TPU keeps driving its result, so tpu_ena stays high here.
`ifdef SEQ_REARM_EN
        if (r_press) begin
          w_snap         = 1'b1;
          w_tpu_rstn_nxt = 1'b0;
          w_disp_ena_nxt = 1'b0;
          w_done_nxt     = 1'b0;
          w_busy_nxt     = 1'b1;
          w_cnt_nxt      = '0;
        end
`endif
      end
      c_S_ERR: begin
        w_tpu_ena_nxt  = 1'b0;
        w_disp_ena_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_busy_nxt     = 1'b0;
      end
      default: begin
        w_vga_rstn_nxt = 1'b1;
        w_tpu_ena_nxt  = 1'b0;
        w_tpu_rstn_nxt = 1'b1;
        w_disp_ena_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_busy_nxt     = 1'b0;
        w_cnt_nxt      = '0;
      end
    endcase
  end

  // Output and counter registers; image and digit load only on their strobes.
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      vga_rstn    <= 1'b1;
      tpu_ena     <= 1'b0;
      tpu_rstn    <= 1'b1;
      tpu_image   <= '0;
      result      <= '0;
      disp_ena    <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      r_cnt       <= '0;
    end else begin
      vga_rstn    <= w_vga_rstn_nxt;
      tpu_ena     <= w_tpu_ena_nxt;
      tpu_rstn    <= w_tpu_rstn_nxt;
      disp_ena    <= w_disp_ena_nxt;
      done        <= w_done_nxt;
      busy        <= w_busy_nxt;
      timeout_err <= w_terr_nxt;
      r_cnt       <= w_cnt_nxt;
      if (w_snap)   tpu_image <= user_image;
      if (w_res_ld) result    <= tpu_num;
    end
  end

endmodule
`default_nettype wire
